// File: rtl/isp_rgb_packer_pkg.sv
// Shared definitions for the RGB packer: channel tag codes and assembly FSM states.
package isp_rgb_packer_pkg;

    // Channel tag width and codes carried on color_in
    localparam int unsigned COLOR_BIT_CNT = 2;

    localparam logic [COLOR_BIT_CNT-1:0] VOID  = 2'd0;
    localparam logic [COLOR_BIT_CNT-1:0] RED   = 2'd1;
    localparam logic [COLOR_BIT_CNT-1:0] GREEN = 2'd2;
    localparam logic [COLOR_BIT_CNT-1:0] BLUE  = 2'd3;

    // Triplet assembly state: which channel is expected next
    typedef enum logic [1:0] {
        S_R = 2'd0,
        S_G = 2'd1,
        S_B = 2'd2
    } asm_state_e;

endpackage

// File: rtl/isp_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A push while full only succeeds when a pop happens in the same cycle.
module isp_sync_fifo #(
    parameter int unsigned WIDTH  = 26,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_pop,
    output logic [WIDTH-1:0]  o_rdata,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_level
);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_level;
    logic              w_push;
    logic              w_pop;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == (ADDR_W+1)'(DEPTH));
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    // Storage, pointers and level; storage is cleared so the head reads 0 after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/isp_rgb_packer.sv
// Assembles tagged R/G/B channel beats into packed 24-bit words, buffers them in a
// FWFT FIFO towards the host, and tracks ordering errors, overflow and row/frame ends.
module isp_rgb_packer
    import isp_rgb_packer_pkg::*;
#(
    parameter int unsigned COLOR_DEPTH = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ADDR_W      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [COLOR_DEPTH-1:0]   pixel_in,
    input  logic                     valid_in,
    input  logic [COLOR_BIT_CNT-1:0] color_in,
    input  logic                     last_col_in,
    input  logic                     last_pic_in,
    input  logic                     clr_err,
    output logic [3*COLOR_DEPTH-1:0] rgb_out,
    output logic                     rgb_valid,
    input  logic                     rgb_ready,
    output logic                     last_col_out,
    output logic                     last_pic_out,
    output logic                     frame_done,
    output logic                     seq_err,
    output logic                     overflow,
    output logic [ADDR_W:0]          level,
    output logic [15:0]              row_cnt
);

    localparam int unsigned WORD_W = 3 * COLOR_DEPTH + 2;

    asm_state_e             r_state;
    logic [COLOR_DEPTH-1:0] r_red;
    logic [COLOR_DEPTH-1:0] r_green;
    logic                   r_seq_err;
    logic                   r_overflow;
    logic                   r_frame_done;
    logic [15:0]            r_row_cnt;

    logic                   w_expected;
    logic                   w_viol;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_drop;
    logic [WORD_W-1:0]      w_wdata;
    logic [WORD_W-1:0]      w_rdata;

    // A beat is in order when its tag matches the channel the FSM is waiting for
    always_comb begin
        w_expected = 1'b0;
        unique case (r_state)
            S_R:     w_expected = (color_in == RED);
            S_G:     w_expected = (color_in == GREEN);
            S_B:     w_expected = (color_in == BLUE);
            default: w_expected = 1'b0;
        endcase
    end

    assign w_viol  = valid_in && !w_expected;
    assign w_push  = valid_in && (r_state == S_B) && (color_in == BLUE);
    assign w_pop   = rgb_valid && rgb_ready;
    assign w_drop  = w_push && w_full && !w_pop;
    assign w_wdata = {r_red, r_green, pixel_in, last_col_in, last_pic_in};

    // Assembly FSM; an out-of-order RED restarts the triplet instead of being lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_R;
            r_red   <= '0;
            r_green <= '0;
        end else if (valid_in) begin
            if (w_expected) begin
                unique case (r_state)
                    S_R: begin
                        r_red   <= pixel_in;
                        r_state <= S_G;
                    end
                    S_G: begin
                        r_green <= pixel_in;
                        r_state <= S_B;
                    end
                    default: r_state <= S_R;
                endcase
            end else if (color_in == RED) begin
                r_red   <= pixel_in;
                r_green <= '0;
                r_state <= S_G;
            end else begin
                r_red   <= '0;
                r_green <= '0;
                r_state <= S_R;
            end
        end
    end

    // Sticky flags: a new error in the clear cycle keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq_err  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_seq_err  <= w_viol || (r_seq_err && !clr_err);
            r_overflow <= w_drop || (r_overflow && !clr_err);
        end
    end

    // Row counting and end-of-frame pulse on the consumer side
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_cnt    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_pop && last_pic_out;
            if (w_pop && last_pic_out) begin
                r_row_cnt <= '0;
            end else if (w_pop && last_col_out) begin
                r_row_cnt <= r_row_cnt + 16'd1;
            end
        end
    end

    isp_sync_fifo #(
        .WIDTH  (WORD_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign rgb_valid    = !w_empty;
    assign rgb_out      = w_rdata[WORD_W-1:2];
    assign last_col_out = w_rdata[1];
    assign last_pic_out = w_rdata[0];
    assign frame_done   = r_frame_done;
    assign seq_err      = r_seq_err;
    assign overflow     = r_overflow;
    assign row_cnt      = r_row_cnt;

endmodule

// File: tb/tb_isp_rgb_packer.sv
// Scoreboard bench for isp_rgb_packer: stimulus pushes expected words, a monitor pops
// and compares on every accepted output and tracks row_cnt / frame_done / head stability.
module tb_isp_rgb_packer;
    import isp_rgb_packer_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [7:0]  pixel_in;
    logic        valid_in;
    logic [1:0]  color_in;
    logic        last_col_in;
    logic        last_pic_in;
    logic        clr_err;
    logic [23:0] rgb_out;
    logic        rgb_valid;
    logic        rgb_ready;
    logic        last_col_out;
    logic        last_pic_out;
    logic        frame_done;
    logic        seq_err;
    logic        overflow;
    logic [4:0]  level;
    logic [15:0] row_cnt;

    logic [25:0] exp_q [$];
    int          n_cmp;
    int          n_bad;
    int          fd_cnt;
    logic [15:0] row_model;
    logic        fd_exp;
    logic        held;
    logic [25:0] held_word;
    logic [25:0] got;

    isp_rgb_packer u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pixel_in     (pixel_in),
        .valid_in     (valid_in),
        .color_in     (color_in),
        .last_col_in  (last_col_in),
        .last_pic_in  (last_pic_in),
        .clr_err      (clr_err),
        .rgb_out      (rgb_out),
        .rgb_valid    (rgb_valid),
        .rgb_ready    (rgb_ready),
        .last_col_out (last_col_out),
        .last_pic_out (last_pic_out),
        .frame_done   (frame_done),
        .seq_err      (seq_err),
        .overflow     (overflow),
        .level        (level),
        .row_cnt      (row_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One beat, presented for exactly one clock; returns 1 time unit after the edge
    task automatic send(input logic [1:0] c, input logic [7:0] p, input logic lc,
                        input logic lp);
        valid_in    = 1'b1;
        color_in    = c;
        pixel_in    = p;
        last_col_in = lc;
        last_pic_in = lp;
        @(posedge clk);
        #1;
        valid_in    = 1'b0;
        color_in    = VOID;
        last_col_in = 1'b0;
        last_pic_in = 1'b0;
    endtask

    task automatic triplet(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                           input logic lc, input logic lp, input logic expect_word);
        send(RED, r, 1'b0, 1'b0);
        send(GREEN, g, 1'b0, 1'b0);
        if (expect_word) exp_q.push_back({r, g, b, lc, lp});
        send(BLUE, b, lc, lp);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait for the FIFO to drain, optionally with random backpressure; bounded
    task automatic drain(input string name, input bit rand_ready);
        for (int i = 0; i < 400; i++) begin
            if (level == 5'd0) break;
            if (rand_ready) rgb_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        chk(name, 32'(level), 32'd0);
    endtask

    // Monitor: compare every accepted word against the scoreboard, model row_cnt and
    // frame_done, and require the head to hold while it is not accepted
    initial begin
        row_model = '0;
        fd_exp    = 1'b0;
        held      = 1'b0;
        held_word = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                row_model = '0;
                fd_exp    = 1'b0;
                held      = 1'b0;
            end else begin
                chk("row_cnt", 32'(row_cnt), 32'(row_model));
                chk("frame_done", 32'(frame_done), 32'(fd_exp));
                if (frame_done) fd_cnt++;
                got = {rgb_out, last_col_out, last_pic_out};
                if (held && rgb_valid) chk("head_stable", 32'(got), 32'(held_word));
                fd_exp = 1'b0;
                if (rgb_valid && rgb_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_word: got %0h expected none", got);
                    end else begin
                        chk("word", 32'(got), 32'(exp_q.pop_front()));
                    end
                    if (last_pic_out) begin
                        row_model = '0;
                        fd_exp    = 1'b1;
                    end else if (last_col_out) begin
                        row_model = row_model + 16'd1;
                    end
                    held = 1'b0;
                end else if (rgb_valid) begin
                    held      = 1'b1;
                    held_word = got;
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        fd_cnt      = 0;
        rst_n       = 1'b0;
        pixel_in    = '0;
        valid_in    = 1'b0;
        color_in    = VOID;
        last_col_in = 1'b0;
        last_pic_in = 1'b0;
        clr_err     = 1'b0;
        rgb_ready   = 1'b0;

        // Reset state
        cycles(3);
        chk("rst_rgb_valid", 32'(rgb_valid), 32'd0);
        chk("rst_rgb_out", 32'(rgb_out), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_seq_err", 32'(seq_err), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_row_cnt", 32'(row_cnt), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        cycles(1);

        // Single pixel, one-cycle latency from the BLUE beat
        rgb_ready = 1'b1;
        triplet(8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 1'b1);
        chk("t1_valid_after_blue", 32'(rgb_valid), 32'd1);
        chk("t1_rgb_out", 32'(rgb_out), 32'h123456);
        chk("t1_last_col", 32'(last_col_out), 32'd1);
        cycles(1);
        chk("t1_row_cnt", 32'(row_cnt), 32'd1);
        chk("t1_level", 32'(level), 32'd0);

        // Order error: BLUE while expecting GREEN drops the partial triplet
        send(RED, 8'hAA, 1'b0, 1'b0);
        send(BLUE, 8'hBB, 1'b0, 1'b0);
        chk("t2_seq_err", 32'(seq_err), 32'd1);
        chk("t2_no_word", 32'(rgb_valid), 32'd0);
        triplet(8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b1);
        cycles(2);
        chk("t2_seq_err_sticky", 32'(seq_err), 32'd1);
        clr_err = 1'b1;
        cycles(1);
        clr_err = 1'b0;
        chk("t2_seq_err_clr", 32'(seq_err), 32'd0);

        // Overflow: 17 triplets into a 16-deep FIFO without consumption
        rgb_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            triplet(8'(i), 8'(8'h40 + i), 8'(8'h80 + i), 1'b0, 1'b0, (i < 16));
        end
        chk("t3_level_full", 32'(level), 32'd16);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_seq_err", 32'(seq_err), 32'd0);
        clr_err = 1'b1;
        cycles(1);
        clr_err = 1'b0;
        chk("t3_overflow_clr", 32'(overflow), 32'd0);

        // Full with simultaneous push and pop: both succeed, level holds
        send(RED, 8'hC1, 1'b0, 1'b0);
        send(GREEN, 8'hC2, 1'b0, 1'b0);
        rgb_ready = 1'b1;
        exp_q.push_back({8'hC1, 8'hC2, 8'hC3, 1'b0, 1'b0});
        send(BLUE, 8'hC3, 1'b0, 1'b0);
        rgb_ready = 1'b0;
        chk("t4_level", 32'(level), 32'd16);
        chk("t4_overflow", 32'(overflow), 32'd0);
        rgb_ready = 1'b1;
        drain("t4_drain", 1'b0);

        // 4x2 frame under random backpressure
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 4; x++) begin
                rgb_ready = 1'($urandom_range(0, 1));
                triplet(8'(8'h10 * y + x), 8'(8'h20 + x), 8'(8'h30 + y),
                        (x == 3), (x == 3 && y == 1), 1'b1);
            end
        end
        drain("t5_drain", 1'b1);
        rgb_ready = 1'b1;
        cycles(3);
        chk("t5_frame_done_cnt", 32'(fd_cnt), 32'd1);
        chk("t5_row_cnt", 32'(row_cnt), 32'd0);

        // Reset mid-triplet: the following BLUE is out of order
        send(RED, 8'h77, 1'b0, 1'b0);
        send(GREEN, 8'h88, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("t6_in_reset_seq_err", 32'(seq_err), 32'd0);
        rst_n = 1'b1;
        #1;
        send(BLUE, 8'h99, 1'b0, 1'b0);
        chk("t6_seq_err", 32'(seq_err), 32'd1);
        chk("t6_level", 32'(level), 32'd0);
        cycles(2);
        chk("t6_rgb_valid", 32'(rgb_valid), 32'd0);

        cycles(2);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
